// File: rtl/control_pipe.sv
// control_pipe: decodes the ID instruction and carries its control word through EX, MEM and WB.
// Stall, flush and compare-and-branch nullification turn the EX load into a bubble; WB validity drives a retire counter.
module control_pipe #(
    parameter int CNT_W   = 32,
    parameter int NULL_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instruction,
    input  logic             stall,
    input  logic             flush,
    input  logic             nullify_in,
    output logic [1:0]       ex_SRD,
    output logic [2:0]       ex_SOH_OP,
    output logic [3:0]       ex_ALU_OP,
    output logic [1:0]       ex_ID_SR,
    output logic             ex_B,
    output logic             ex_UB,
    output logic [3:0]       mem_RAM_CTRL,
    output logic             mem_L,
    output logic [1:0]       mem_PSW_LE_RE,
    output logic             wb_RF_LE,
    output logic [1:0]       wb_SRD,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_cnt
);
    typedef struct packed {
        logic [1:0] srd;
        logic [2:0] soh_op;
        logic [3:0] alu_op;
        logic [1:0] id_sr;
        logic       b;
        logic       ub;
        logic [3:0] ram_ctrl;
        logic       l;
        logic [1:0] psw_le_re;
        logic       rf_le;
        logic       valid;
    } ctrl_t;

    typedef enum logic {IDLE, NULLIFY} state_t;

    localparam ctrl_t NOP = '0;

    ctrl_t      dec, ex;
    logic       unknown, dec_illegal, kill;
    logic [5:0] op, sub;
    state_t     state, state_nxt;
    logic [3:0] mem_ram_ctrl;
    logic       mem_l, mem_rf_le, mem_valid, wb_rf_le, wb_valid;
    logic [1:0] mem_psw_le_re, mem_srd, wb_srd;

    assign op  = instruction[31:26];
    assign sub = instruction[11:6];

    always_comb begin
        dec     = NOP;
        unknown = 1'b0;
        case (op)
            6'b000010: begin
                dec.rf_le = 1'b1;
                dec.id_sr = 2'b11;
                case (sub)
                    6'b011000: {dec.alu_op, dec.psw_le_re} = {4'b0000, 2'b01};
                    6'b011100: {dec.alu_op, dec.psw_le_re} = {4'b0001, 2'b11};
                    6'b101000: {dec.alu_op, dec.psw_le_re} = {4'b0000, 2'b00};
                    6'b010000: {dec.alu_op, dec.psw_le_re} = {4'b0010, 2'b01};
                    6'b010100: {dec.alu_op, dec.psw_le_re} = {4'b0011, 2'b11};
                    6'b001000: {dec.alu_op, dec.psw_le_re} = {4'b0111, 2'b00};
                    6'b001001: {dec.alu_op, dec.psw_le_re} = {4'b0101, 2'b00};
                    6'b001010: {dec.alu_op, dec.psw_le_re} = {4'b0110, 2'b00};
                    default:   unknown = 1'b1;
                endcase
            end
            6'b010010, 6'b010001, 6'b010000: begin
                dec.srd      = 2'b10;
                dec.soh_op   = 3'b010;
                dec.l        = 1'b1;
                dec.rf_le    = 1'b1;
                dec.id_sr    = 2'b10;
                dec.ram_ctrl = op == 6'b010010 ? 4'b1001 : op == 6'b010001 ? 4'b0101 : 4'b0001;
            end
            6'b011010, 6'b011001, 6'b011000: begin
                dec.srd      = 2'b11;
                dec.soh_op   = 3'b010;
                dec.id_sr    = 2'b11;
                dec.ram_ctrl = op == 6'b011010 ? 4'b1011 : op == 6'b011001 ? 4'b0111 : 4'b0011;
            end
            6'b001101: begin
                dec.srd    = 2'b10;
                dec.soh_op = 3'b010;
                dec.rf_le  = 1'b1;
                dec.id_sr  = 2'b01;
            end
            6'b001000: begin
                dec.srd    = 2'b01;
                dec.soh_op = 3'b011;
                dec.alu_op = 4'b1010;
                dec.rf_le  = 1'b1;
            end
            6'b111010: begin
                dec.srd   = 2'b01;
                dec.b     = 1'b1;
                dec.ub    = 1'b1;
                dec.rf_le = 1'b1;
            end
            6'b100000, 6'b100010: begin
                dec.srd    = 2'b11;
                dec.b      = 1'b1;
                dec.alu_op = 4'b0010;
                dec.id_sr  = 2'b11;
            end
            6'b101101, 6'b100101: begin
                dec.srd       = 2'b10;
                dec.psw_le_re = 2'b01;
                dec.soh_op    = 3'b001;
                dec.rf_le     = 1'b1;
                dec.id_sr     = 2'b01;
                dec.alu_op    = op == 6'b100101 ? 4'b0010 : 4'b0000;
            end
            default: unknown = 1'b1;
        endcase
        // The all-zero word is the canonical NOP and must not be treated as an unknown opcode.
        if (unknown || instruction == '0) dec = NOP;
        else dec.valid = 1'b1;
    end

    assign dec_illegal = unknown && instruction != '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (NULL_EN != 0 && ex.b && !ex.ub && nullify_in) ? NULLIFY : IDLE;
            NULLIFY: state_nxt = (flush || !stall) ? IDLE : NULLIFY;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        kill = state == NULLIFY;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex            <= NOP;
            mem_ram_ctrl  <= '0;
            mem_l         <= 1'b0;
            mem_psw_le_re <= '0;
            mem_rf_le     <= 1'b0;
            mem_srd       <= '0;
            mem_valid     <= 1'b0;
            wb_rf_le      <= 1'b0;
            wb_srd        <= '0;
            wb_valid      <= 1'b0;
            illegal       <= 1'b0;
            retired_cnt   <= '0;
        end else begin
            ex            <= (flush || stall || kill) ? NOP : dec;
            mem_ram_ctrl  <= ex.ram_ctrl;
            mem_l         <= ex.l;
            mem_psw_le_re <= ex.psw_le_re;
            mem_rf_le     <= ex.rf_le;
            mem_srd       <= ex.srd;
            mem_valid     <= ex.valid;
            wb_rf_le      <= mem_rf_le;
            wb_srd        <= mem_srd;
            wb_valid      <= mem_valid;
            if (dec_illegal) illegal <= 1'b1;
            if (wb_valid) retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

    assign ex_SRD        = ex.srd;
    assign ex_SOH_OP     = ex.soh_op;
    assign ex_ALU_OP     = ex.alu_op;
    assign ex_ID_SR      = ex.id_sr;
    assign ex_B          = ex.b;
    assign ex_UB         = ex.ub;
    assign mem_RAM_CTRL  = mem_ram_ctrl;
    assign mem_L         = mem_l;
    assign mem_PSW_LE_RE = mem_psw_le_re;
    assign wb_RF_LE      = wb_rf_le;
    assign wb_SRD        = wb_srd;
endmodule

// File: tb/tb_control_pipe.sv
// tb_control_pipe: directed checks of control_pipe with default parameters and with CNT_W=4, NULL_EN=0.
module tb_control_pipe;
    localparam logic [31:0] ADD  = {6'b000010, 14'd0, 6'b011000, 6'd0};
    localparam logic [31:0] ADDC = {6'b000010, 14'd0, 6'b011100, 6'd0};
    localparam logic [31:0] SUB  = {6'b000010, 14'd0, 6'b010000, 6'd0};
    localparam logic [31:0] AND_ = {6'b000010, 14'd0, 6'b001000, 6'd0};
    localparam logic [31:0] LDW  = {6'b010010, 26'd0};
    localparam logic [31:0] STW  = {6'b011010, 26'd0};
    localparam logic [31:0] LDO  = {6'b001101, 26'd0};
    localparam logic [31:0] LDIL = {6'b001000, 26'd0};
    localparam logic [31:0] BL   = {6'b111010, 26'd0};
    localparam logic [31:0] ADDI = {6'b101101, 26'd0};
    localparam logic [31:0] SUBI = {6'b100101, 26'd0};
    localparam logic [31:0] COMBT= {6'b100000, 26'd0};
    localparam logic [31:0] ILL  = {6'b111111, 26'd0};

    logic        clk, reset, stall, flush, nullify_in;
    logic [31:0] instruction;
    logic [1:0]  ex_SRD, ex_ID_SR, mem_PSW_LE_RE, wb_SRD;
    logic [2:0]  ex_SOH_OP;
    logic [3:0]  ex_ALU_OP, mem_RAM_CTRL;
    logic        ex_B, ex_UB, mem_L, wb_RF_LE, illegal;
    logic [31:0] retired_cnt;
    logic [1:0]  b_ex_SRD, b_ex_ID_SR, b_mem_PSW_LE_RE, b_wb_SRD;
    logic [2:0]  b_ex_SOH_OP;
    logic [3:0]  b_ex_ALU_OP, b_mem_RAM_CTRL;
    logic        b_ex_B, b_ex_UB, b_mem_L, b_wb_RF_LE, b_illegal;
    logic [3:0]  b_retired_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;

    control_pipe dut (
        .clk(clk), .reset(reset), .instruction(instruction), .stall(stall), .flush(flush),
        .nullify_in(nullify_in), .ex_SRD(ex_SRD), .ex_SOH_OP(ex_SOH_OP), .ex_ALU_OP(ex_ALU_OP),
        .ex_ID_SR(ex_ID_SR), .ex_B(ex_B), .ex_UB(ex_UB), .mem_RAM_CTRL(mem_RAM_CTRL), .mem_L(mem_L),
        .mem_PSW_LE_RE(mem_PSW_LE_RE), .wb_RF_LE(wb_RF_LE), .wb_SRD(wb_SRD), .illegal(illegal),
        .retired_cnt(retired_cnt)
    );

    control_pipe #(.CNT_W(4), .NULL_EN(0)) dut2 (
        .clk(clk), .reset(reset), .instruction(instruction), .stall(stall), .flush(flush),
        .nullify_in(nullify_in), .ex_SRD(b_ex_SRD), .ex_SOH_OP(b_ex_SOH_OP), .ex_ALU_OP(b_ex_ALU_OP),
        .ex_ID_SR(b_ex_ID_SR), .ex_B(b_ex_B), .ex_UB(b_ex_UB), .mem_RAM_CTRL(b_mem_RAM_CTRL), .mem_L(b_mem_L),
        .mem_PSW_LE_RE(b_mem_PSW_LE_RE), .wb_RF_LE(b_wb_RF_LE), .wb_SRD(b_wb_SRD), .illegal(b_illegal),
        .retired_cnt(b_retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1; instruction = '0; stall = 1'b0; flush = 1'b0; nullify_in = 1'b0;
        steps(2);
        chk("rst_ex_alu", ex_ALU_OP, 0);
        chk("rst_wb_rf_le", wb_RF_LE, 0);
        chk("rst_cnt", retired_cnt, 0);
        chk("rst_illegal", illegal, 0);
        reset = 1'b0;

        // ADD latency through EX, MEM, WB and the counter
        instruction = ADD;
        steps(1);
        chk("add_ex_alu", ex_ALU_OP, 4'b0000);
        chk("add_ex_id_sr", ex_ID_SR, 2'b11);
        instruction = '0;
        steps(1);
        chk("add_mem_psw", mem_PSW_LE_RE, 2'b01);
        chk("add_ex_gone", ex_ID_SR, 2'b00);
        steps(1);
        chk("add_wb_rf_le", wb_RF_LE, 1);
        chk("add_cnt_c3", retired_cnt, 0);
        steps(1);
        chk("add_cnt_c4", retired_cnt, 1);
        chk("add_wb_gone", wb_RF_LE, 0);

        // ALU sub-ops back to back
        instruction = ADDC;
        steps(1);
        chk("addc_ex_alu", ex_ALU_OP, 4'b0001);
        instruction = SUB;
        steps(1);
        chk("sub_ex_alu", ex_ALU_OP, 4'b0010);
        chk("addc_mem_psw", mem_PSW_LE_RE, 2'b11);
        instruction = AND_;
        steps(1);
        chk("and_ex_alu", ex_ALU_OP, 4'b0111);
        chk("sub_mem_psw", mem_PSW_LE_RE, 2'b01);
        instruction = '0;
        steps(1);
        chk("and_mem_psw", mem_PSW_LE_RE, 2'b00);
        steps(3);
        chk("alu_cnt", retired_cnt, 4);
        chk("alu_cnt_b", b_retired_cnt, 4);

        // LDW then a one-cycle stall
        instruction = LDW;
        steps(1);
        chk("ldw_ex_srd", ex_SRD, 2'b10);
        chk("ldw_ex_soh", ex_SOH_OP, 3'b010);
        stall = 1'b1; instruction = STW;
        steps(1);
        chk("ldw_mem_ram", mem_RAM_CTRL, 4'b1001);
        chk("ldw_mem_l", mem_L, 1);
        chk("stall_bubble_srd", ex_SRD, 2'b00);
        chk("stall_bubble_idsr", ex_ID_SR, 2'b00);
        stall = 1'b0;
        steps(1);
        chk("stw_ex_srd", ex_SRD, 2'b11);
        chk("bubble_mem_ram", mem_RAM_CTRL, 4'b0000);
        chk("bubble_mem_l", mem_L, 0);
        instruction = '0;
        steps(1);
        chk("stw_mem_ram", mem_RAM_CTRL, 4'b1011);
        chk("stw_mem_l", mem_L, 0);
        steps(3);
        chk("ldst_cnt", retired_cnt, 6);

        // simultaneous flush and stall, then the remaining formats
        flush = 1'b1; stall = 1'b1; instruction = LDO;
        steps(1);
        chk("flush_ex_srd", ex_SRD, 2'b00);
        chk("flush_ex_soh", ex_SOH_OP, 3'b000);
        flush = 1'b0; stall = 1'b0; instruction = LDIL;
        steps(1);
        chk("ldil_ex_srd", ex_SRD, 2'b01);
        chk("ldil_ex_soh", ex_SOH_OP, 3'b011);
        chk("ldil_ex_alu", ex_ALU_OP, 4'b1010);
        instruction = BL;
        steps(1);
        chk("bl_ex_b", ex_B, 1);
        chk("bl_ex_ub", ex_UB, 1);
        chk("bl_ex_srd", ex_SRD, 2'b01);
        instruction = ADDI;
        steps(1);
        chk("addi_ex_soh", ex_SOH_OP, 3'b001);
        chk("addi_ex_id_sr", ex_ID_SR, 2'b01);
        chk("addi_ex_b", ex_B, 0);
        instruction = SUBI;
        steps(1);
        chk("subi_ex_alu", ex_ALU_OP, 4'b0010);
        chk("addi_mem_psw", mem_PSW_LE_RE, 2'b01);
        instruction = '0;
        steps(1);
        chk("subi_mem_psw", mem_PSW_LE_RE, 2'b01);
        steps(3);
        chk("flush_cnt", retired_cnt, 10);
        chk("flush_cnt_b", b_retired_cnt, 10);

        // COMBT nullification of the next decode
        instruction = COMBT;
        steps(1);
        chk("combt_ex_b", ex_B, 1);
        chk("combt_ex_ub", ex_UB, 0);
        chk("combt_ex_alu", ex_ALU_OP, 4'b0010);
        nullify_in = 1'b1; instruction = '0;
        steps(1);
        nullify_in = 1'b0; instruction = ADD;
        steps(1);
        chk("null_ex_id_sr", ex_ID_SR, 2'b00);
        chk("nonull_ex_id_sr_b", b_ex_ID_SR, 2'b11);
        instruction = SUB;
        steps(1);
        chk("post_null_ex_alu", ex_ALU_OP, 4'b0010);
        instruction = '0;
        steps(4);
        chk("null_cnt", retired_cnt, 12);
        chk("nonull_cnt_b", b_retired_cnt, 13);

        // sticky illegal opcode
        chk("pre_illegal", illegal, 0);
        instruction = ILL;
        steps(1);
        chk("illegal_set", illegal, 1);
        chk("illegal_set_b", b_illegal, 1);
        chk("illegal_ex_nop", ex_ID_SR, 2'b00);
        instruction = ADD;
        steps(10);
        instruction = '0;
        chk("illegal_sticky", illegal, 1);
        steps(3);
        chk("ill_cnt", retired_cnt, 22);
        chk("ill_cnt_b", b_retired_cnt, 7);

        // asynchronous reset between edges
        instruction = SUB;
        steps(3);
        chk("pre_rst_ex_alu", ex_ALU_OP, 4'b0010);
        chk("pre_rst_wb_rf_le", wb_RF_LE, 1);
        #1 reset = 1'b1;
        #1;
        chk("arst_ex_alu", ex_ALU_OP, 0);
        chk("arst_ex_id_sr", ex_ID_SR, 0);
        chk("arst_mem_psw", mem_PSW_LE_RE, 0);
        chk("arst_wb_rf_le", wb_RF_LE, 0);
        chk("arst_cnt", retired_cnt, 0);
        chk("arst_cnt_b", b_retired_cnt, 0);
        chk("arst_illegal", illegal, 0);
        instruction = ADD;
        @(posedge clk);
        #1 reset = 1'b0;

        // counter wrap with CNT_W=4
        steps(1);
        chk("resume_ex_id_sr", ex_ID_SR, 2'b11);
        steps(15);
        instruction = '0;
        steps(2);
        chk("wrap_pre_b", b_retired_cnt, 15);
        chk("wrap_pre", retired_cnt, 15);
        steps(1);
        chk("wrap_b", b_retired_cnt, 0);
        chk("wrap_wide", retired_cnt, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
